teclado_matricial: RTL and testbench
====================================

// Module: teclado_matricial
// PURPOSE
//   Scans a 4x4 matrix keypad, debounces it and produces the 5-bit key code consumed by the
//   chronometer/calculator top as its key input.
//   Level output: holds the code while the key is held and T_NULL otherwise.
//   Also gives a one-cycle new-press strobe.
//   Runs on the same 1 kHz system clock.
// PARAMETERS
//   COL_CYCLES      3   clocks each column is driven before its rows are sampled (>=3, covers 2-flop sync)
//   DEBOUNCE_SCANS  2   consecutive identical full scans needed to accept a press or a release
//   REPEAT_SCANS    25  scans between auto-repeat strobes (used only with TECLADO_REPEAT_EN)
// PORTS
//   clk        in   1  system clock (1 kHz)
//   rst_n      in   1  asynchronous reset, active low
//   rows       in   4  keypad rows, active low (external pull-ups), asynchronous
//   cols       out  4  keypad column drive, active low; exactly one column low while scanning
//   key        out  5  debounced key code (TECLAS encoding), T_NULL when no key is accepted
//   key_valid  out  1  one-cycle strobe when key changes to a non-NULL code (and on repeat)
// BEHAVIOUR
//   Reset values: cols=4'b1110, key=T_NULL, key_valid=0, FSMs in initial state, all counters 0.
//   Synchronisation: rows pass through a 2-flop synchroniser; only synchronised rows are used.
//   Scan FSM: S_COL (dwell counter 0..COL_CYCLES-1) -> S_SAMPLE -> next column.
//     - In S_SAMPLE, latch the 4 synchronised rows for the current column. Column index wraps 3->0.
//     - After column 3 is sampled, spend one S_EVAL cycle, then restart at column 0.
//     - Scan period = 4*(COL_CYCLES+1)+1 clocks (17 at the defaults).
//   Raw result of a scan:
//     - no low row in any column -> T_NULL;
//     - exactly one low row/column pair -> that code;
//     - two or more -> T_NULL (ghosting rejection; no priority encoding).
//   Layout (row,col):
//     r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: * 0 # D.
//   Encoding:
//     - T_0..T_9 = 0..9, T_A..T_D = 10..13, T_ASTE = 14, T_HASH = 15, T_NULL = 5'h10.
//   Debounce FSM, evaluated once per scan in S_EVAL:
//     - RELEASED: raw!=T_NULL -> PRESS_PEND, cand<=raw, cnt<=1.
//     - PRESS_PEND: raw==cand -> cnt++.
//       - On cnt reaching DEBOUNCE_SCANS: go to PRESSED, key<=cand, key_valid=1 for the next cycle.
//       - raw!=cand -> RELEASED (cand discarded; a different code restarts from RELEASED next scan).
//     - PRESSED: raw==key -> stay.
//       - Otherwise -> RELEASE_PEND, cnt<=1.
//     - RELEASE_PEND: raw==key -> PRESSED (bounce, key unchanged, no strobe).
//       - Otherwise cnt++. On reaching DEBOUNCE_SCANS: key<=T_NULL, go to RELEASED.
//   Latency: key updates 1 clock after S_EVAL of the accepting scan; key_valid is coincident with the update.
//   Key rollover: a second key while the first is held gives raw=T_NULL (ghost) or a new code.
//     Either leads to release of the first key. A new code is then accepted only via RELEASED->PRESS_PEND.
//   key_valid is never asserted for T_NULL and never for two consecutive cycles.
//   Reset mid-scan: everything returns to reset values immediately (async). A key already pressed at
//     reset release is accepted as a fresh press after DEBOUNCE_SCANS scans.
// CONFIGURATION
//   TECLADO_REPEAT_EN defined:
//     - While in PRESSED, a repeat counter counts scans. Every REPEAT_SCANS scans it re-pulses key_valid.
//     - key stays constant. The counter clears on entry to PRESSED and in every other state.
//   Not defined: no repeat logic, key_valid only on acceptance. The REPEAT_SCANS parameter is ignored.
// STRUCTURE
//   Shared package TECLAS: the T_* key codes (including T_NULL) and the row/column -> code layout
//     function. The top and calculator use the same package.
//   Sub-module sincronizador_2ff (width-parameterised 2-flop synchroniser) for rows.
//   Scan FSM and debounce FSM stay in this module.
// TESTING
//   1. Press '5' (row1/col1 low) clean for 5 scans.
//      -> key=5 after the 2nd S_EVAL +1 clk; one key_valid pulse; cols rotate 1110,1101,1011,0111.
//   2. '#' bouncing (present 1 scan, absent 1 scan, then stable) -> no output during the bounce;
//      then key=15 after 2 stable scans; exactly one key_valid.
//   3. Hold 'D' then release -> key=13; key returns to 5'h10 two scans after release; no strobe on release.
//   4. Press '1' and '5' together (ghost) -> key stays 5'h10, key_valid never asserted.
//   5. Assert rst_n=0 mid-column while key=7 -> key=5'h10, cols=1110 at once.
//      After rst_n=1 with '7' held -> key=7 again after 2 scans.
//   6. With TECLADO_REPEAT_EN, hold '*' for 80 scans -> key=14; key_valid at acceptance plus 3 repeats
//      (every 25 scans). Without the macro -> exactly 1 pulse.

Source files
------------

// File: rtl/teclado_matricial_pkg.sv
// Shared key-code package (TECLAS) for the keypad scanner and the
// chronometer/calculator top.
//   teclas_e       : T_0..T_9 = 0..9, T_A..T_D = 10..13, T_ASTE = 14,
//                    T_HASH = 15, T_NULL = 5'h10 (no key)
//   scan_state_e   : column scan FSM states
//   deb_state_e    : debounce FSM states
//   tecla_de()     : (row, col) of the 4x4 keypad -> key code
package teclado_matricial_pkg;

   typedef enum logic [4:0] {
      T_0    = 5'd0,
      T_1    = 5'd1,
      T_2    = 5'd2,
      T_3    = 5'd3,
      T_4    = 5'd4,
      T_5    = 5'd5,
      T_6    = 5'd6,
      T_7    = 5'd7,
      T_8    = 5'd8,
      T_9    = 5'd9,
      T_A    = 5'd10,
      T_B    = 5'd11,
      T_C    = 5'd12,
      T_D    = 5'd13,
      T_ASTE = 5'd14,
      T_HASH = 5'd15,
      T_NULL = 5'h10
   } teclas_e;

   typedef enum logic [1:0] {
      S_COL    = 2'd0,
      S_SAMPLE = 2'd1,
      S_EVAL   = 2'd2
   } scan_state_e;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_PEND   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_PEND = 2'd3
   } deb_state_e;

   // Keypad layout: r0: 1 2 3 A / r1: 4 5 6 B / r2: 7 8 9 C / r3: * 0 # D
   function automatic logic [4:0] tecla_de(input logic [1:0] row, input logic [1:0] col);
      logic [4:0] code;
      case ({row, col})
         4'h0:    code = T_1;
         4'h1:    code = T_2;
         4'h2:    code = T_3;
         4'h3:    code = T_A;
         4'h4:    code = T_4;
         4'h5:    code = T_5;
         4'h6:    code = T_6;
         4'h7:    code = T_B;
         4'h8:    code = T_7;
         4'h9:    code = T_8;
         4'hA:    code = T_9;
         4'hB:    code = T_C;
         4'hC:    code = T_ASTE;
         4'hD:    code = T_0;
         4'hE:    code = T_HASH;
         4'hF:    code = T_D;
         default: code = T_NULL;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/teclado_matricial_sincronizador_2ff.sv
// sincronizador_2ff: width-parameterised two-flop synchroniser for
// asynchronous inputs.
//   clk    in  1      destination clock
//   rst_n  in  1      asynchronous reset, active low
//   d      in  WIDTH  asynchronous input
//   q      out WIDTH  synchronised output (two clocks of latency)
// RST_VAL sets the idle level held while in reset.
module sincronizador_2ff #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_d, meta_q;
   logic [WIDTH-1:0] sync_d, sync_q;

   // Next-state of the two synchroniser stages
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchroniser flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/teclado_matricial.sv
// teclado_matricial: 4x4 matrix keypad scanner with debounce.
// Drives one column low at a time, samples the synchronised rows, and once
// per full scan feeds the decoded raw key to a debounce FSM.
//   clk        in   1  system clock (1 kHz)
//   rst_n      in   1  asynchronous reset, active low
//   rows       in   4  keypad rows, active low, asynchronous
//   cols       out  4  column drive, active low, one column low at a time
//   key        out  5  debounced key code, T_NULL when no key accepted
//   key_valid  out  1  one-cycle strobe on acceptance of a new key
// Optional feature macro: TECLADO_REPEAT_EN -- re-pulses key_valid every
// REPEAT_SCANS scans while a key stays held.
module teclado_matricial
   import teclado_matricial_pkg::*;
#(
   parameter int COL_CYCLES     = 3,
   parameter int DEBOUNCE_SCANS = 2,
   parameter int REPEAT_SCANS   = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [4:0] key,
   output logic       key_valid
);

   localparam int DWELL_W = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(COL_CYCLES - 1);
   // One width serves both the debounce and the repeat scan counters
   localparam int CNT_MAX = (REPEAT_SCANS > DEBOUNCE_SCANS) ? REPEAT_SCANS : DEBOUNCE_SCANS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
`ifdef TECLADO_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_TARGET = CNT_W'(REPEAT_SCANS);
`endif

   logic [3:0]         rows_s;
   scan_state_e        scan_state_d, scan_state_q;
   logic [DWELL_W-1:0] dwell_d, dwell_q;
   logic [1:0]         col_d, col_q;
   logic [15:0]        matrix_d, matrix_q;   // bit col*4+row set = key closed
   logic [3:0]         cols_d, cols_q;
   logic [4:0]         hits_s;
   logic [4:0]         hit_code_s;
   logic [4:0]         raw_s;
   deb_state_e         deb_state_d, deb_state_q;
   logic [4:0]         cand_d, cand_q;
   logic [CNT_W-1:0]   cnt_d, cnt_q;
   logic [4:0]         key_d, key_q;
   logic               key_valid_d, key_valid_q;
`ifdef TECLADO_REPEAT_EN
   logic [CNT_W-1:0]   rep_cnt_d, rep_cnt_q;
`endif

   // Rows idle high, so the synchroniser resets to "no key"
   sincronizador_2ff #(
      .WIDTH   (4),
      .RST_VAL (4'hF)
   ) u_sync_rows (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rows),
      .q     (rows_s)
   );

   // Column scan FSM: dwell on each column, sample it, evaluate after column 3
   always_comb begin
      scan_state_d = scan_state_q;
      dwell_d      = dwell_q;
      col_d        = col_q;
      matrix_d     = matrix_q;
      case (scan_state_q)
         S_COL: begin
            if (dwell_q == DWELL_LAST) begin
               dwell_d      = {DWELL_W{1'b0}};
               scan_state_d = S_SAMPLE;
            end else begin
               dwell_d = dwell_q + DWELL_W'(1);
            end
         end
         S_SAMPLE: begin
            matrix_d[{col_q, 2'b00} +: 4] = ~rows_s;
            if (col_q == 2'd3) begin
               scan_state_d = S_EVAL;
            end else begin
               col_d        = col_q + 2'd1;
               scan_state_d = S_COL;
            end
         end
         S_EVAL: begin
            col_d        = 2'd0;
            scan_state_d = S_COL;
         end
         default: begin
            scan_state_d = S_COL;
            dwell_d      = {DWELL_W{1'b0}};
            col_d        = 2'd0;
         end
      endcase
      // Column 3 stays driven through S_EVAL since col_q only moves on after it
      cols_d = ~(4'b0001 << col_d);
   end

   // Raw key of the last complete scan; more than one closure is a ghost -> T_NULL
   always_comb begin
      hits_s     = 5'd0;
      hit_code_s = 5'd0;
      for (int i = 0; i < 16; i++) begin
         hits_s     = hits_s + {4'd0, matrix_q[i[3:0]]};
         hit_code_s = hit_code_s | (matrix_q[i[3:0]] ? tecla_de(i[1:0], i[3:2]) : 5'd0);
      end
      raw_s = (hits_s == 5'd1) ? hit_code_s : T_NULL;
   end

   // Debounce FSM, advanced only in the S_EVAL cycle of each scan
   always_comb begin
      deb_state_d = deb_state_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      key_d       = key_q;
      key_valid_d = 1'b0;
`ifdef TECLADO_REPEAT_EN
      // Repeat count survives only while sitting in PRESSED
      rep_cnt_d   = (deb_state_q == PRESSED) ? rep_cnt_q : CNT_ZERO;
`endif
      if (scan_state_q == S_EVAL) begin
         case (deb_state_q)
            RELEASED: begin
               if (raw_s != T_NULL) begin
                  deb_state_d = PRESS_PEND;
                  cand_d      = raw_s;
                  cnt_d       = CNT_ONE;
               end else begin
                  cand_d = T_NULL;
                  cnt_d  = CNT_ZERO;
               end
            end
            PRESS_PEND: begin
               if (raw_s == cand_q) begin
                  if ((cnt_q + CNT_ONE) >= DEB_TARGET) begin
                     deb_state_d = PRESSED;
                     key_d       = cand_q;
                     key_valid_d = 1'b1;
                     cnt_d       = CNT_ZERO;
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end else begin
                  // A different code must start over from RELEASED next scan
                  deb_state_d = RELEASED;
                  cand_d      = T_NULL;
                  cnt_d       = CNT_ZERO;
               end
            end
            PRESSED: begin
               if (raw_s == key_q) begin
`ifdef TECLADO_REPEAT_EN
                  if ((rep_cnt_q + CNT_ONE) >= REP_TARGET) begin
                     rep_cnt_d   = CNT_ZERO;
                     key_valid_d = 1'b1;
                  end else begin
                     rep_cnt_d = rep_cnt_q + CNT_ONE;
                  end
`else
                  deb_state_d = PRESSED;
`endif
               end else begin
                  deb_state_d = RELEASE_PEND;
                  cnt_d       = CNT_ONE;
`ifdef TECLADO_REPEAT_EN
                  rep_cnt_d   = CNT_ZERO;
`endif
               end
            end
            RELEASE_PEND: begin
               if (raw_s == key_q) begin
                  // Bounce on release: back to PRESSED silently
                  deb_state_d = PRESSED;
                  cnt_d       = CNT_ZERO;
               end else if ((cnt_q + CNT_ONE) >= DEB_TARGET) begin
                  deb_state_d = RELEASED;
                  key_d       = T_NULL;
                  cnt_d       = CNT_ZERO;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               deb_state_d = RELEASED;
               cand_d      = T_NULL;
               cnt_d       = CNT_ZERO;
               key_d       = T_NULL;
            end
         endcase
      end else begin
         deb_state_d = deb_state_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_state_q <= S_COL;
         dwell_q      <= {DWELL_W{1'b0}};
         col_q        <= 2'd0;
         matrix_q     <= 16'h0000;
         cols_q       <= 4'b1110;
         deb_state_q  <= RELEASED;
         cand_q       <= T_NULL;
         cnt_q        <= CNT_ZERO;
         key_q        <= T_NULL;
         key_valid_q  <= 1'b0;
`ifdef TECLADO_REPEAT_EN
         rep_cnt_q    <= CNT_ZERO;
`endif
      end else begin
         scan_state_q <= scan_state_d;
         dwell_q      <= dwell_d;
         col_q        <= col_d;
         matrix_q     <= matrix_d;
         cols_q       <= cols_d;
         deb_state_q  <= deb_state_d;
         cand_q       <= cand_d;
         cnt_q        <= cnt_d;
         key_q        <= key_d;
         key_valid_q  <= key_valid_d;
`ifdef TECLADO_REPEAT_EN
         rep_cnt_q    <= rep_cnt_d;
`endif
      end
   end

   assign cols      = cols_q;
   assign key       = key_q;
   assign key_valid = key_valid_q;

endmodule

// File: tb/tb_teclado_matricial.sv
// Directed bench for teclado_matricial. A behavioural keypad pulls a row low
// when its key is held and its column is driven low. Timing is counted in
// clocks from reset release: scan s evaluates in cycle 17*s+16, so an
// accepted key is visible from cycle 17*(s+1).
module tb_teclado_matricial;
   import teclado_matricial_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic [4:0]  key;
   logic        key_valid;

   logic [15:0] pressed = 16'h0000;   // bit row*4+col = key held
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          valid_cnt = 0;
   int          viol = 0;
   logic        prev_valid = 1'b0;
   int          v0;

`ifdef TECLADO_REPEAT_EN
   localparam int   STAR_PULSES = 4;
   localparam logic REP_AT_544  = 1'b1;
`else
   localparam int   STAR_PULSES = 1;
   localparam logic REP_AT_544  = 1'b0;
`endif

   always #5 clk = ~clk;

   teclado_matricial dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rows      (rows),
      .cols      (cols),
      .key       (key),
      .key_valid (key_valid)
   );

   // keypad model
   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
   end

   // clocks since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // strobe monitor: count pulses, flag NULL or back-to-back strobes
   always @(negedge clk) begin
      if (key_valid) begin
         valid_cnt <= valid_cnt + 1;
         if (prev_valid || key == T_NULL) viol <= viol + 1;
      end
      prev_valid <= key_valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic goto(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset values ----
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cols", cols, 4'b1110);
      chk("rst_key", key, 5'h10);
      chk("rst_valid", key_valid, 1'b0);

      // ---- 1: clean '5' (r1,c1) for scans 0..4 ----
      pressed = 16'h0020;
      rst_n = 1'b1;
      v0 = valid_cnt;
      goto(0);  chk("t1_cols0", cols, 4'b1110);
      goto(4);  chk("t1_cols1", cols, 4'b1101);
      goto(8);  chk("t1_cols2", cols, 4'b1011);
      goto(12); chk("t1_cols3", cols, 4'b0111);
      goto(16); chk("t1_cols_eval", cols, 4'b0111);
      goto(17); chk("t1_cols_wrap", cols, 4'b1110);
      goto(33); chk("t1_key_early", key, 5'h10);
                chk("t1_valid_early", key_valid, 1'b0);
      goto(34); chk("t1_key", key, 5'd5);
                chk("t1_valid", key_valid, 1'b1);
      goto(35); chk("t1_valid_1cyc", key_valid, 1'b0);
      goto(85); pressed = 16'h0000;
      goto(118); chk("t1_key_held", key, 5'd5);
      goto(119); chk("t1_key_rel", key, 5'h10);
                 chk("t1_valid_rel", key_valid, 1'b0);
      chk("t1_pulses", valid_cnt - v0, 1);

      // ---- 2: '#' (r3,c2) bounces: scan 8 on, scan 9 off, stable from 10 ----
      v0 = valid_cnt;
      goto(136); pressed = 16'h4000;
      goto(153); pressed = 16'h0000;
      goto(170); chk("t2_bounce_key", key, 5'h10);
                 chk("t2_bounce_pulses", valid_cnt - v0, 0);
                 pressed = 16'h4000;
      goto(203); chk("t2_key_early", key, 5'h10);
      goto(204); chk("t2_key", key, 5'd15);
                 chk("t2_valid", key_valid, 1'b1);
      goto(221); pressed = 16'h0000;
      goto(254); chk("t2_key_held", key, 5'd15);
      goto(255); chk("t2_key_rel", key, 5'h10);
      chk("t2_pulses", valid_cnt - v0, 1);

      // ---- 3: hold 'D' (r3,c3), release at scan 20 ----
      v0 = valid_cnt;
      pressed = 16'h8000;
      goto(288); chk("t3_key_early", key, 5'h10);
      goto(289); chk("t3_key", key, 5'd13);
                 chk("t3_valid", key_valid, 1'b1);
      goto(340); pressed = 16'h0000;
      goto(373); chk("t3_key_held", key, 5'd13);
      goto(374); chk("t3_key_rel", key, 5'h10);
                 chk("t3_valid_rel", key_valid, 1'b0);
      goto(376); chk("t3_pulses", valid_cnt - v0, 1);

      // ---- 4: '1' and '5' together (ghost) for scans 22..27 ----
      v0 = valid_cnt;
      pressed = 16'h0021;
      goto(408); chk("t4_key_a", key, 5'h10);
      goto(459); chk("t4_key_b", key, 5'h10);
      goto(476); chk("t4_key_c", key, 5'h10);
                 chk("t4_pulses", valid_cnt - v0, 0);

      // ---- 5: '7' (r2,c0) accepted, then reset mid-column ----
      pressed = 16'h0100;
      goto(509); chk("t5_key_early", key, 5'h10);
      goto(510); chk("t5_key", key, 5'd7);
                 chk("t5_valid", key_valid, 1'b1);
      goto(516); chk("t5_cols_mid", cols, 4'b1101);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_rst_key", key, 5'h10);
      chk("t5_rst_cols", cols, 4'b1110);
      chk("t5_rst_valid", key_valid, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      v0 = valid_cnt;
      goto(33); chk("t5_re_key_early", key, 5'h10);
      goto(34); chk("t5_re_key", key, 5'd7);
                chk("t5_re_valid", key_valid, 1'b1);
      goto(51); pressed = 16'h0000;
      goto(85); chk("t5_key_rel", key, 5'h10);
                chk("t5_pulses", valid_cnt - v0, 1);

      // ---- 6: hold '*' (r3,c0) for 80 scans (5..84) ----
      v0 = valid_cnt;
      pressed = 16'h1000;
      goto(119);  chk("t6_key", key, 5'd14);
                  chk("t6_valid", key_valid, 1'b1);
      goto(544);  chk("t6_repeat_pulse", key_valid, REP_AT_544);
                  chk("t6_key_mid", key, 5'd14);
      goto(1428); chk("t6_key_late", key, 5'd14);
      goto(1445); pressed = 16'h0000;
      goto(1479); chk("t6_key_rel", key, 5'h10);
      goto(1481); chk("t6_pulses", valid_cnt - v0, STAR_PULSES);

      // ---- strobe never on NULL, never two cycles in a row ----
      chk("strobe_rules", viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
